// File: rtl/controle_multiciclo_param.sv
// Multicycle MIPS control FSM with configurable memory wait states.
// Define EXCEPTION_EN to trap undefined opcodes into the EXCECAO state.
module controle_multiciclo_param #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPcode,
  input  logic [5:0] funct,
  output logic       EscreveMem,
  output logic       EscrevePC,
  output logic       EscrevePCCondEQ,
  output logic       EscrevePCCondNE,
  output logic       EscreveReg,
  output logic       RegDst,
  output logic       IouD,
  output logic       EscreveIR,
  output logic       EscreveMDR,
  output logic       EscreveAluOut,
  output logic       OrigAALU,
  output logic       EscreveEPC,
  output logic [1:0] OrigPC,
  output logic [1:0] MemparaReg,
  output logic [1:0] OrigBALU,
  output logic [1:0] OpALU,
  output logic [5:0] State
);

  typedef enum logic [5:0] {
    S_MEM_READ    = 6'd0,
    S_ESPERA      = 6'd1,
    S_IR_WRITE    = 6'd2,
    S_DECODE      = 6'd3,
    S_CLASSE_R    = 6'd4,
    S_WRITE_RD    = 6'd5,
    S_REF_MEM     = 6'd6,
    S_LOAD        = 6'd7,
    S_LOAD_WAIT   = 6'd8,
    S_LOAD_MDR    = 6'd9,
    S_END_REF_MEM = 6'd10,
    S_STORE       = 6'd11,
    S_BEQ         = 6'd12,
    S_BNE         = 6'd13,
    S_LUI         = 6'd14,
    S_JUMP        = 6'd15,
    S_ADDI        = 6'd16,
    S_WRITE_RT    = 6'd17,
    S_NOP         = 6'd18,
    S_BREAK       = 6'd19
`ifdef EXCEPTION_EN
    ,
    S_EXCECAO     = 6'd20
`endif
  } state_t;

  localparam logic       NO_WAIT = (MEM_WAIT == 0);
  localparam logic [3:0] WAIT_LD =
    (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic       epc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_MEM_READ;
      cnt   <= 4'd0;
    end else begin
      state <= nxt;
      // load on entry into a wait state, then count down to 0 and hold
      if ((nxt == S_ESPERA && state != S_ESPERA) ||
          (nxt == S_LOAD_WAIT && state != S_LOAD_WAIT))
        cnt <= WAIT_LD;
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    nxt             = state;
    EscreveMem      = 1'b0;
    EscrevePC       = 1'b0;
    EscrevePCCondEQ = 1'b0;
    EscrevePCCondNE = 1'b0;
    EscreveReg      = 1'b0;
    RegDst          = 1'b0;
    IouD            = 1'b0;
    EscreveIR       = 1'b0;
    EscreveMDR      = 1'b0;
    EscreveAluOut   = 1'b0;
    OrigAALU        = 1'b0;
    epc             = 1'b0;
    OrigPC          = 2'b00;
    MemparaReg      = 2'b00;
    OrigBALU        = 2'b00;
    OpALU           = 2'b00;
    case (state)
      S_MEM_READ: nxt = NO_WAIT ? S_IR_WRITE : S_ESPERA;
      S_ESPERA: if (cnt == 4'd0) nxt = S_IR_WRITE;
      S_IR_WRITE: begin
        EscreveIR = 1'b1;
        EscrevePC = 1'b1;
        OrigBALU  = 2'b01;
        nxt       = S_DECODE;
      end
      S_DECODE: begin
        OrigBALU      = 2'b11;
        EscreveAluOut = 1'b1;
        unique case (1'b1)
          OPcode == 6'h00 && funct == 6'h0d: nxt = S_BREAK;
          OPcode == 6'h00 && funct == 6'h00: nxt = S_NOP;
          OPcode == 6'h00 && funct != 6'h0d
            && funct != 6'h00:              nxt = S_CLASSE_R;
          OPcode == 6'h02:                   nxt = S_JUMP;
          OPcode == 6'h04:                   nxt = S_BEQ;
          OPcode == 6'h05:                   nxt = S_BNE;
          OPcode == 6'h08:                   nxt = S_ADDI;
          OPcode == 6'h0f:                   nxt = S_LUI;
          OPcode == 6'h23 || OPcode == 6'h2b: nxt = S_REF_MEM;
          default:
`ifdef EXCEPTION_EN
            nxt = S_EXCECAO;
`else
            nxt = S_NOP;
`endif
        endcase
      end
      S_CLASSE_R: begin
        OrigAALU      = 1'b1;
        OpALU         = 2'b10;
        EscreveAluOut = 1'b1;
        nxt           = S_WRITE_RD;
      end
      S_WRITE_RD: begin
        RegDst     = 1'b1;
        EscreveReg = 1'b1;
        nxt        = S_MEM_READ;
      end
      S_REF_MEM: begin
        OrigAALU      = 1'b1;
        OrigBALU      = 2'b10;
        EscreveAluOut = 1'b1;
        nxt = (OPcode == 6'h23) ? S_LOAD : S_STORE;
      end
      S_LOAD: begin
        IouD = 1'b1;
        nxt  = NO_WAIT ? S_LOAD_MDR : S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        IouD = 1'b1;
        if (cnt == 4'd0) nxt = S_LOAD_MDR;
      end
      S_LOAD_MDR: begin
        IouD       = 1'b1;
        EscreveMDR = 1'b1;
        nxt        = S_END_REF_MEM;
      end
      S_END_REF_MEM: begin
        MemparaReg = 2'b01;
        EscreveReg = 1'b1;
        nxt        = S_MEM_READ;
      end
      S_STORE: begin
        IouD       = 1'b1;
        EscreveMem = 1'b1;
        nxt        = S_MEM_READ;
      end
      S_BEQ: begin
        OrigAALU        = 1'b1;
        OpALU           = 2'b01;
        OrigPC          = 2'b01;
        EscrevePCCondEQ = 1'b1;
        nxt             = S_MEM_READ;
      end
      S_BNE: begin
        OrigAALU        = 1'b1;
        OpALU           = 2'b01;
        OrigPC          = 2'b01;
        EscrevePCCondNE = 1'b1;
        nxt             = S_MEM_READ;
      end
      S_LUI: begin
        MemparaReg = 2'b10;
        EscreveReg = 1'b1;
        nxt        = S_MEM_READ;
      end
      S_JUMP: begin
        OrigPC    = 2'b10;
        EscrevePC = 1'b1;
        nxt       = S_MEM_READ;
      end
      S_ADDI: begin
        OrigAALU      = 1'b1;
        OrigBALU      = 2'b10;
        EscreveAluOut = 1'b1;
        nxt           = S_WRITE_RT;
      end
      S_WRITE_RT: begin
        EscreveReg = 1'b1;
        nxt        = S_MEM_READ;
      end
      S_NOP:   nxt = S_MEM_READ;
      S_BREAK: nxt = S_BREAK;
`ifdef EXCEPTION_EN
      S_EXCECAO: begin
        epc       = 1'b1;
        EscrevePC = 1'b1;
        OrigPC    = 2'b11;
        nxt       = S_MEM_READ;
      end
`endif
      default: nxt = S_MEM_READ;
    endcase
  end

`ifdef EXCEPTION_EN
  assign EscreveEPC = epc;
`else
  assign EscreveEPC = 1'b0;
`endif

  assign State = state;

endmodule

// File: tb/tb_controle_multiciclo_param.sv
// Scoreboard bench: three DUTs (MEM_WAIT 0, 1, 3) share stimulus,
// each checked cycle by cycle against an expected state/output trace.
module tb_controle_multiciclo_param;

  typedef struct packed {
    logic       mem;
    logic       pc;
    logic       eq;
    logic       ne;
    logic       rw;
    logic       rdst;
    logic       iord;
    logic       ir;
    logic       mdr;
    logic       alo;
    logic       srca;
    logic       epc;
    logic [1:0] opc;
    logic [1:0] m2r;
    logic [1:0] srcb;
    logic [1:0] aluop;
  } outs_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_LUI = 3, C_ADDI = 4;
  localparam int C_BEQ = 5, C_BNE = 6, C_J = 7, C_NOP = 8;
  localparam int C_UND = 9, C_BRK = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] fn;
  logic [5:0] st [3];
  outs_t      act [3];
  logic [5:0] expq [3][$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  function automatic int wof(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       mem, pc, eq, ne, rw, rdst, iord, ir, mdr, alo, srca, epc;
    logic [1:0] opc, m2r, srcb, aluop;
    logic [5:0] s;
    controle_multiciclo_param #(
      .MEM_WAIT(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clock(clk),
      .reset(reset),
      .OPcode(op),
      .funct(fn),
      .EscreveMem(mem),
      .EscrevePC(pc),
      .EscrevePCCondEQ(eq),
      .EscrevePCCondNE(ne),
      .EscreveReg(rw),
      .RegDst(rdst),
      .IouD(iord),
      .EscreveIR(ir),
      .EscreveMDR(mdr),
      .EscreveAluOut(alo),
      .OrigAALU(srca),
      .EscreveEPC(epc),
      .OrigPC(opc),
      .MemparaReg(m2r),
      .OrigBALU(srcb),
      .OpALU(aluop),
      .State(s)
    );
    assign st[g]  = s;
    assign act[g] = {mem, pc, eq, ne, rw, rdst, iord, ir, mdr, alo,
                     srca, epc, opc, m2r, srcb, aluop};
  end

  // Output table per state, written out from the control description
  function automatic outs_t exp_outs(input logic [5:0] s);
    outs_t o;
    o = '0;
    case (s)
      6'd2:  begin o.ir = 1; o.pc = 1; o.srcb = 2'b01; end
      6'd3:  begin o.srcb = 2'b11; o.alo = 1; end
      6'd4:  begin o.srca = 1; o.aluop = 2'b10; o.alo = 1; end
      6'd5:  begin o.rdst = 1; o.rw = 1; end
      6'd6:  begin o.srca = 1; o.srcb = 2'b10; o.alo = 1; end
      6'd7:  o.iord = 1;
      6'd8:  o.iord = 1;
      6'd9:  begin o.iord = 1; o.mdr = 1; end
      6'd10: begin o.m2r = 2'b01; o.rw = 1; end
      6'd11: begin o.iord = 1; o.mem = 1; end
      6'd12: begin o.srca = 1; o.aluop = 2'b01; o.opc = 2'b01; o.eq = 1; end
      6'd13: begin o.srca = 1; o.aluop = 2'b01; o.opc = 2'b01; o.ne = 1; end
      6'd14: begin o.m2r = 2'b10; o.rw = 1; end
      6'd15: begin o.opc = 2'b10; o.pc = 1; end
      6'd16: begin o.srca = 1; o.srcb = 2'b10; o.alo = 1; end
      6'd17: o.rw = 1;
      6'd20: begin o.epc = 1; o.pc = 1; o.opc = 2'b11; end
      default: o = '0;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (expq[k].size() > 0) begin
        logic [5:0] e;
        outs_t      eo;
        e  = expq[k].pop_front();
        eo = exp_outs(e);
        tests++;
        if (st[k] !== e || act[k] !== eo) begin
          fails++;
          $display("FAIL w%0d trace: state got=%0d exp=%0d outs got=%h exp=%h",
                   wof(k), st[k], e, act[k], eo);
        end
      end
    end
  end

  task automatic push_instr(input int k, input int cls);
    int w;
    w = wof(k);
    expq[k].push_back(6'd0);
    repeat (w) expq[k].push_back(6'd1);
    expq[k].push_back(6'd2);
    expq[k].push_back(6'd3);
    case (cls)
      C_LW: begin
        expq[k].push_back(6'd6);
        expq[k].push_back(6'd7);
        repeat (w) expq[k].push_back(6'd8);
        expq[k].push_back(6'd9);
        expq[k].push_back(6'd10);
      end
      C_SW:   begin expq[k].push_back(6'd6); expq[k].push_back(6'd11); end
      C_R:    begin expq[k].push_back(6'd4); expq[k].push_back(6'd5); end
      C_ADDI: begin expq[k].push_back(6'd16); expq[k].push_back(6'd17); end
      C_LUI:  expq[k].push_back(6'd14);
      C_BEQ:  expq[k].push_back(6'd12);
      C_BNE:  expq[k].push_back(6'd13);
      C_J:    expq[k].push_back(6'd15);
      C_NOP:  expq[k].push_back(6'd18);
`ifdef EXCEPTION_EN
      C_UND:  expq[k].push_back(6'd20);
`else
      C_UND:  expq[k].push_back(6'd18);
`endif
      default: repeat (12) expq[k].push_back(6'd19);
    endcase
    if (cls != C_BRK) expq[k].push_back(6'd0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) > 0
           && n < 60) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (n >= 60) begin
      fails++;
      $display("FAIL %s timeout: pending got=%0d exp=0", name,
               expq[0].size() + expq[1].size() + expq[2].size());
      for (int k = 0; k < 3; k++) expq[k].delete();
    end
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f,
                     input int cls, input string name);
    @(posedge clk);
    #1;
    reset = 1'b1;
    op    = o;
    fn    = f;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) push_instr(k, cls);
    drain(name);
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'h00;
    fn    = 6'h00;
    run(6'h23, 6'h00, C_LW,   "lw");
    run(6'h2b, 6'h00, C_SW,   "sw");
    run(6'h00, 6'h20, C_R,    "rtype");
    run(6'h0f, 6'h00, C_LUI,  "lui");
    run(6'h08, 6'h00, C_ADDI, "addi");
    run(6'h04, 6'h00, C_BEQ,  "beq");
    run(6'h05, 6'h00, C_BNE,  "bne");
    run(6'h02, 6'h00, C_J,    "jump");
    run(6'h00, 6'h00, C_NOP,  "nop");
    run(6'h3f, 6'h00, C_UND,  "undef");
    run(6'h00, 6'h0d, C_BRK,  "break");
    // reset taken while parked in BREAK
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) expq[k].push_back(6'd0);
    drain("brk_reset");
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo_param.md
# controle_multiciclo_param

Parametrised multicycle MIPS control unit: a Moore FSM driving the datapath's mux selects and write enables for fetch, decode and execute. It replaces the fixed-latency controller. Memory wait states are configurable, ADDI is added, and LUI, SW and LW/SW dispatch are corrected. An optional undefined-opcode exception path is available. It sits between the instruction register (OPcode/funct) and the datapath.

## Interface
- MEM_WAIT, 1, number of wait cycles between issuing a memory read and data valid; legal range 0..15.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- OPcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- EscreveMem, EscrevePC, EscrevePCCondEQ, EscrevePCCondNE  out  1 each  memory write, unconditional PC write, PC write if ALU zero, PC write if not zero.
- EscreveReg, RegDst, IouD, EscreveIR, EscreveMDR, EscreveAluOut, OrigAALU  out  1 each  register file write, rd(1)/rt(0) select, ALUOut(1)/PC(0) address select, IR, MDR and ALUOut enables, A(1)/PC(0) select.
- EscreveEPC  out  1  EPC write enable.
- OrigPC  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- MemparaReg  out  2  register write data select: 00 ALUOut, 01 MDR, 10 {imm,16'h0}.
- OrigBALU  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- OpALU  out  2  00 add, 01 sub, 10 decode funct.
- State  out  6  current state encoding.

## Operation
- Outputs are Moore (state only). Every output is 0 in every state except where it is listed below.
- State encodings and asserted outputs:
  - MEM_READ=0: IouD=0, read issued.
  - ESPERA=1: holds for MEM_WAIT cycles.
  - IR_WRITE=2: EscreveIR, EscrevePC, OrigBALU=01 (PC<=PC+4).
  - DECODE=3: OrigBALU=11, EscreveAluOut (branch target).
  - CLASSE_R=4: OrigAALU, OpALU=10, EscreveAluOut.
  - WRITE_RD=5: RegDst, EscreveReg.
  - REF_MEM=6: OrigAALU, OrigBALU=10, EscreveAluOut.
  - LOAD=7, LOAD_WAIT=8: IouD.
  - LOAD_MDR=9: IouD, EscreveMDR.
  - END_REF_MEM=10: MemparaReg=01, EscreveReg.
  - STORE=11: IouD, EscreveMem.
  - BEQ=12 / BNE=13: OrigAALU, OpALU=01, OrigPC=01, EscrevePCCondEQ or EscrevePCCondNE respectively.
  - LUI=14: MemparaReg=10, EscreveReg.
  - JUMP=15: OrigPC=10, EscrevePC.
  - ADDI=16: OrigAALU, OrigBALU=10, EscreveAluOut.
  - WRITE_RT=17: EscreveReg.
  - NOP=18: no outputs.
  - BREAK=19: no outputs.
  - EXCECAO=20: EscreveEPC, EscrevePC, OrigPC=11.
- Fetch sequence: MEM_READ -> ESPERA (skipped when MEM_WAIT=0) -> IR_WRITE -> DECODE.
- DECODE dispatch:
  - OPcode 0: funct 0x0d -> BREAK; funct 0x00 -> NOP; any other funct -> CLASSE_R.
  - 0x02 -> JUMP; 0x04 -> BEQ; 0x05 -> BNE; 0x08 -> ADDI; 0x0f -> LUI; 0x23 or 0x2b -> REF_MEM.
  - Any other opcode -> see Configuration.
- Execute sequences:
  - REF_MEM goes to LOAD if OPcode=0x23, otherwise to STORE.
  - LOAD -> LOAD_WAIT (skipped when MEM_WAIT=0) -> LOAD_MDR -> END_REF_MEM.
  - CLASSE_R -> WRITE_RD; ADDI -> WRITE_RT.
  - STORE, WRITE_RD, WRITE_RT, END_REF_MEM, BEQ, BNE, LUI, JUMP, NOP and EXCECAO each return to MEM_READ.
  - BREAK holds until reset.
- Wait counter: 4 bits, loaded with MEM_WAIT-1 on entry to ESPERA/LOAD_WAIT, decremented each cycle; the state exits when the counter is 0 and the counter holds at 0.

## Timing
- Reset: at the first rising edge with reset=1, State=MEM_READ and counter=0. All outputs then read 0. This applies in any state, including mid-wait and BREAK.
- Cycles per instruction (W=MEM_WAIT):
  - Fetch and decode: W+3.
  - BEQ, BNE, J, LUI, NOP: W+4.
  - R-type, ADDI, SW: W+5.
  - LW: 2W+7.
- DECODE samples OPcode/funct one cycle after the IR write, so the IR value is stable.
- OPcode must stay stable from DECODE to instruction end (IR is not written outside IR_WRITE).

## Configuration
- EXCEPTION_EN defined: an undefined opcode goes from DECODE to EXCECAO. EXCECAO asserts EscreveEPC=1, EscrevePC=1 and OrigPC=11 for one cycle, then goes to MEM_READ. EPC captures PC+4 of the faulting instruction.
- EXCEPTION_EN undefined: an undefined opcode goes to NOP. The EXCECAO state does not exist, EscreveEPC is tied 0, and OrigPC never equals 11.

## Test plan
- MEM_WAIT=1; reset high for 2 cycles, then release -> State=0 with all outputs 0; the fetch sequence 0,1,2,3 is observed.
- MEM_WAIT=3; OPcode=0x23 -> states 0,1,1,1,2,3,6,7,8,8,8,9,10,0, i.e. 13 cycles (2W+7) before the next MEM_READ. END_REF_MEM shows MemparaReg=01 and EscreveReg=1.
- MEM_WAIT=0; OPcode=0x2b -> states 0,2,3,6,11,0. EscreveMem=1 only in STORE, and EscreveReg stays 0 throughout.
- OPcode=0, funct=0x20 -> CLASSE_R then WRITE_RD with RegDst=1. OPcode=0x0f -> LUI with MemparaReg=10 and RegDst=0.
- OPcode=0x3f: with EXCEPTION_EN, state 20 is entered with EscreveEPC=1 and OrigPC=11. Without it, state 18 is entered. In both cases the FSM then returns to 0.
- funct=0x0d with OPcode=0 -> BREAK holds for 10 or more cycles; asserting reset mid-BREAK gives State=0 on the next edge.
